// File: rtl/ahb_lite_copy_master.sv
// rtl/ahb_lite_copy_master.sv - AHB-Lite master that copies a block of words from SRC to DST
//
// Purpose: accepts a start/src/dst/len command and moves LEN 32-bit words,
// each as one SINGLE NONSEQ read followed by one SINGLE NONSEQ write.
// Wait states and two-cycle ERROR responses are honoured. An error aborts the
// copy and sets the sticky ERR flag.
//
// Ports:
//   CLK, RES_N                      clock, asynchronous active-low reset
//   START, SRC, DST, LEN            command (START sampled only when idle and not busy)
//   BUSY, DONE, ERR                 status (DONE is a one-cycle pulse, ERR is sticky)
//   M_HTRANS .. M_HWDATA            AHB-Lite master request outputs
//   M_HREADY, M_HRDATA, M_HRESP     AHB-Lite master response inputs
module ahb_lite_copy_master #(
    parameter int unsigned LEN_WIDTH = 16,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic                 CLK,
    input  logic                 RES_N,
    input  logic                 START,
    input  logic [31:0]          SRC,
    input  logic [31:0]          DST,
    input  logic [LEN_WIDTH-1:0] LEN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR,
    output logic [1:0]           M_HTRANS,
    output logic                 M_HWRITE,
    output logic                 M_HMASTLOCK,
    output logic [2:0]           M_HSIZE,
    output logic [2:0]           M_HBURST,
    output logic [3:0]           M_HPROT,
    output logic [31:0]          M_HADDR,
    output logic [31:0]          M_HWDATA,
    input  logic                 M_HREADY,
    input  logic [31:0]          M_HRDATA,
    input  logic                 M_HRESP
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RA,   // read address phase
        S_RD,   // read data phase
        S_WA,   // write address phase
        S_WD,   // write data phase
        S_EA    // second cycle of an ERROR response
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          src_q, src_d;
    logic [31:0]          dst_q, dst_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          buf_q, buf_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [1:0]           htrans;
    logic                 hwrite;
    logic [31:0]          haddr;

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        htrans  = HTRANS_IDLE;
        hwrite  = 1'b0;
        haddr   = src_q;

        case (state_q)
            S_IDLE: begin
                // BUSY stays up through the DONE cycle; a START seen in that
                // cycle is dropped because busy_q is still set.
                if (done_q) begin
                    busy_d = 1'b0;
                end
                if (START && !busy_q) begin
                    src_d = SRC & 32'hFFFF_FFFC;
                    dst_d = DST & 32'hFFFF_FFFC;
                    cnt_d = LEN;
                    err_d = 1'b0;
                    if (LEN == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RA;
                        busy_d  = 1'b1;
                    end
                end
            end

            S_RA: begin
                htrans = HTRANS_NONSEQ;
                haddr  = src_q;
                if (M_HREADY) begin
                    state_d = S_RD;
                end
            end

            S_RD: begin
                if (M_HRESP) begin
                    state_d = S_EA;
                end else if (M_HREADY) begin
                    buf_d   = M_HRDATA;
                    state_d = S_WA;
                end
            end

            S_WA: begin
                htrans = HTRANS_NONSEQ;
                hwrite = 1'b1;
                haddr  = dst_q;
                if (M_HREADY) begin
                    state_d = S_WD;
                end
            end

            S_WD: begin
                if (M_HRESP) begin
                    state_d = S_EA;
                end else if (M_HREADY) begin
                    src_d = src_q + 32'd4;
                    dst_d = dst_q + 32'd4;
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RA;
                    end
                end
            end

            S_EA: begin
                // ERROR completes on its second cycle, when HREADY returns high.
                if (M_HREADY) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign ERR         = err_q;
    assign M_HTRANS    = htrans;
    assign M_HWRITE    = hwrite;
    assign M_HADDR     = haddr;
    // The buffer only changes at the end of a read data phase, so it is
    // stable for the whole write data phase including any stall cycles.
    assign M_HWDATA    = buf_q;
    assign M_HMASTLOCK = 1'b0;
    assign M_HSIZE     = 3'b010;
    assign M_HBURST    = 3'b000;
    assign M_HPROT     = HPROT_VAL;

endmodule

// File: tb/tb_ahb_lite_copy_master.sv
// tb/tb_ahb_lite_copy_master.sv - self-checking bench for ahb_lite_copy_master
module tb_ahb_lite_copy_master;

    logic        CLK = 1'b0;
    logic        RES_N = 1'b0;
    logic        START = 1'b0;
    logic [31:0] SRC = '0;
    logic [31:0] DST = '0;
    logic [15:0] LEN = '0;
    logic        BUSY, DONE, ERR;
    logic [1:0]  M_HTRANS;
    logic        M_HWRITE, M_HMASTLOCK;
    logic [2:0]  M_HSIZE, M_HBURST;
    logic [3:0]  M_HPROT;
    logic [31:0] M_HADDR, M_HWDATA;
    logic        M_HREADY = 1'b1;
    logic [31:0] M_HRDATA = '0;
    logic        M_HRESP = 1'b0;

    ahb_lite_copy_master #(.LEN_WIDTH(16), .HPROT_VAL(4'b0011)) dut (
        .CLK(CLK), .RES_N(RES_N), .START(START), .SRC(SRC), .DST(DST), .LEN(LEN),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE), .M_HMASTLOCK(M_HMASTLOCK),
        .M_HSIZE(M_HSIZE), .M_HBURST(M_HBURST), .M_HPROT(M_HPROT),
        .M_HADDR(M_HADDR), .M_HWDATA(M_HWDATA),
        .M_HREADY(M_HREADY), .M_HRDATA(M_HRDATA), .M_HRESP(M_HRESP)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- slave model and bus monitor (runs on negedge) ----------------
    logic [31:0] mem [logic [31:0]];
    int          cfg_waits = 0;
    int          cfg_err_kind = 0;   // 0 none, 1 read, 2 write
    int          cfg_err_idx = 0;

    bit          dp_valid = 0;
    bit          dp_write = 0;
    logic [31:0] dp_addr = '0;
    int          dp_wait = 0;
    int          dp_err = 0;
    bit          wd_seen = 0;
    logic [31:0] wd_first = '0;

    int          cyc = 0;
    int          first_ns = -1;
    int          done_cyc = -1;
    int          done_cnt = 0;
    int          n_nonseq = 0;
    int          n_writes = 0;
    int          n_rd_iss = 0;
    int          n_wr_iss = 0;
    int          n_busy = 0;
    int          bad_htrans = 0;
    int          wd_unstable = 0;
    logic        busy_at_done = 0;
    logic [31:0] rd_log[$];
    logic [31:0] wr_log[$];

    task automatic mon_clear();
        first_ns = -1; done_cyc = -1; done_cnt = 0; n_nonseq = 0; n_writes = 0;
        n_rd_iss = 0; n_wr_iss = 0; n_busy = 0; bad_htrans = 0; wd_unstable = 0;
        busy_at_done = 0; rd_log.delete(); wr_log.delete();
    endtask

    always @(negedge CLK) begin
        logic hr, rs;
        if (!RES_N) begin
            dp_valid = 0;
            M_HREADY = 1'b1;
            M_HRESP  = 1'b0;
        end else begin
            cyc++;
            hr = 1'b1;
            rs = 1'b0;
            if (dp_valid) begin
                if (dp_err == 1) begin
                    hr = 1'b0; rs = 1'b1; dp_err = 2;
                end else if (dp_err == 2) begin
                    hr = 1'b1; rs = 1'b1; dp_valid = 0;
                end else begin
                    if (dp_write) begin
                        if (!wd_seen) begin wd_first = M_HWDATA; wd_seen = 1; end
                        else if (M_HWDATA !== wd_first) wd_unstable++;
                    end
                    if (dp_wait > 0) begin
                        hr = 1'b0; dp_wait--;
                    end else begin
                        if (dp_write) begin
                            mem[dp_addr] = M_HWDATA;
                            n_writes++;
                        end else begin
                            M_HRDATA = mem.exists(dp_addr) ? mem[dp_addr] : 32'hDEADBEEF;
                        end
                        dp_valid = 0;
                    end
                end
            end
            if (M_HTRANS == 2'b10 && hr) begin
                n_nonseq++;
                if (first_ns < 0) first_ns = cyc;
                dp_valid = 1; dp_write = M_HWRITE; dp_addr = M_HADDR;
                dp_wait = cfg_waits; wd_seen = 0; dp_err = 0;
                if (M_HWRITE) begin
                    n_wr_iss++; wr_log.push_back(M_HADDR);
                    if (cfg_err_kind == 2 && n_wr_iss == cfg_err_idx) dp_err = 1;
                end else begin
                    n_rd_iss++; rd_log.push_back(M_HADDR);
                    if (cfg_err_kind == 1 && n_rd_iss == cfg_err_idx) dp_err = 1;
                end
            end
            if (M_HTRANS != 2'b00 && M_HTRANS != 2'b10) bad_htrans++;
            if (BUSY) n_busy++;
            if (DONE) begin done_cnt++; done_cyc = cyc; busy_at_done = BUSY; end
            M_HREADY = hr;
            M_HRESP  = rs;
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [31:0] src, dst, src_al, dst_al;
        int len, waits, err_kind, err_idx, exp_lat, exp_err, exp_writes, exp_nonseq;
    } vec_t;
    vec_t vecs[7];

    function automatic logic [31:0] pat(input int v, input int i);
        return 32'h11111111 * (i + 1) + (v << 4);
    endfunction

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(posedge CLK); #1;
        SRC = s; DST = d; LEN = l; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (done_cnt == 0 && t < 300) begin @(posedge CLK); #1; t++; end
        chk({name, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
    endtask

    initial begin
        vecs[0] = '{32'h100, 32'h200, 32'h100, 32'h200, 3, 0, 0, 0, 12, 0, 3, 6};
        vecs[1] = '{32'h500, 32'h600, 32'h500, 32'h600, 2, 2, 0, 0, 16, 0, 2, 4};
        vecs[2] = '{32'h700, 32'h800, 32'h700, 32'h800, 1, 1, 0, 0, 6, 0, 1, 2};
        vecs[3] = '{32'h900, 32'hA00, 32'h900, 32'hA00, 4, 0, 1, 2, 7, 1, 1, 3};
        vecs[4] = '{32'hFFFFFFFC, 32'h300, 32'hFFFFFFFC, 32'h300, 2, 0, 0, 0, 8, 0, 2, 4};
        vecs[5] = '{32'h1003, 32'h2002, 32'h1000, 32'h2000, 1, 0, 0, 0, 4, 0, 1, 2};
        vecs[6] = '{32'hD00, 32'hE00, 32'hD00, 32'hE00, 3, 0, 2, 2, 9, 1, 1, 4};

        // Reset values and constant outputs
        #12;
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_done", 32'(DONE), 0);
        chk("rst_err", 32'(ERR), 0);
        chk("rst_htrans", 32'(M_HTRANS), 0);
        chk("rst_hwrite", 32'(M_HWRITE), 0);
        chk("rst_haddr", M_HADDR, 0);
        chk("rst_hwdata", M_HWDATA, 0);
        chk("const_hsize", 32'(M_HSIZE), 32'd2);
        chk("const_hburst", 32'(M_HBURST), 0);
        chk("const_hprot", 32'(M_HPROT), 32'd3);
        chk("const_hmastlock", 32'(M_HMASTLOCK), 0);
        @(posedge CLK); #1; RES_N = 1'b1;
        repeat (2) @(posedge CLK);

        // Table-driven copies
        for (int v = 0; v < 7; v++) begin
            string nm;
            nm = $sformatf("v%0d", v);
            mem.delete();
            for (int i = 0; i < vecs[v].len; i++) mem[vecs[v].src_al + 32'(4 * i)] = pat(v, i);
            cfg_waits = vecs[v].waits; cfg_err_kind = vecs[v].err_kind; cfg_err_idx = vecs[v].err_idx;
            mon_clear();
            do_start(vecs[v].src, vecs[v].dst, 16'(vecs[v].len));
            wait_done(nm);
            repeat (4) @(posedge CLK);
            #1;
            chk({nm, "_latency"}, 32'(done_cyc - first_ns), 32'(vecs[v].exp_lat));
            chk({nm, "_err"}, 32'(ERR), 32'(vecs[v].exp_err));
            chk({nm, "_done_cnt"}, 32'(done_cnt), 1);
            chk({nm, "_busy_at_done"}, 32'(busy_at_done), 1);
            chk({nm, "_busy_after"}, 32'(BUSY), 0);
            chk({nm, "_writes"}, 32'(n_writes), 32'(vecs[v].exp_writes));
            chk({nm, "_nonseq"}, 32'(n_nonseq), 32'(vecs[v].exp_nonseq));
            chk({nm, "_hwdata_stable"}, 32'(wd_unstable), 0);
            chk({nm, "_htrans_legal"}, 32'(bad_htrans), 0);
            for (int i = 0; i < rd_log.size(); i++)
                chk($sformatf("%s_rdaddr%0d", nm, i), rd_log[i], vecs[v].src_al + 32'(4 * i));
            for (int i = 0; i < wr_log.size(); i++)
                chk($sformatf("%s_wraddr%0d", nm, i), wr_log[i], vecs[v].dst_al + 32'(4 * i));
            for (int i = 0; i < vecs[v].exp_writes; i++) begin
                logic [31:0] a;
                a = vecs[v].dst_al + 32'(4 * i);
                chk($sformatf("%s_data%0d", nm, i), mem.exists(a) ? mem[a] : 32'hBAD0BAD0, pat(v, i));
            end
            if (vecs[v].exp_writes < vecs[v].len)
                chk({nm, "_no_extra_write"},
                    32'(mem.exists(vecs[v].dst_al + 32'(4 * vecs[v].exp_writes))), 0);
        end

        // LEN=0 right after the write-error copy: ERR clears, DONE next cycle, no bus traffic
        cfg_waits = 0; cfg_err_kind = 0;
        chk("len0_err_before", 32'(ERR), 1);
        mon_clear();
        do_start(32'h100, 32'h200, 16'd0);
        chk("len0_done", 32'(DONE), 1);
        chk("len0_busy", 32'(BUSY), 0);
        chk("len0_err_cleared", 32'(ERR), 0);
        @(posedge CLK); #1;
        chk("len0_done_pulse", 32'(DONE), 0);
        repeat (4) @(posedge CLK);
        #1;
        chk("len0_nonseq", 32'(n_nonseq), 0);
        chk("len0_busy_cycles", 32'(n_busy), 0);

        // START while busy, including a START in the DONE cycle
        mem.delete();
        mem[32'hB00] = 32'hCAFE0001;
        mem[32'hB04] = 32'hCAFE0002;
        cfg_waits = 1;
        mon_clear();
        do_start(32'hB00, 32'hC00, 16'd2);
        repeat (3) @(posedge CLK);
        #1;
        SRC = 32'hB00; DST = 32'h400; LEN = 16'd5; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        begin
            int t;
            t = 0;
            while (!DONE && t < 100) begin @(posedge CLK); #1; t++; end
            chk("busy_done_seen", 32'(DONE), 1);
            SRC = 32'hB00; DST = 32'h400; LEN = 16'd1; START = 1'b1;
            @(posedge CLK); #1;
            START = 1'b0;
            chk("busy_after_done", 32'(BUSY), 0);
        end
        repeat (6) @(posedge CLK);
        #1;
        chk("busy_latency", 32'(done_cyc - first_ns), 32'd12);
        chk("busy_done_cnt", 32'(done_cnt), 1);
        chk("busy_nonseq", 32'(n_nonseq), 4);
        chk("busy_no_0x400", 32'(mem.exists(32'h400)), 0);
        chk("busy_data0", mem.exists(32'hC00) ? mem[32'hC00] : 32'hBAD0BAD0, 32'hCAFE0001);
        chk("busy_data1", mem.exists(32'hC04) ? mem[32'hC04] : 32'hBAD0BAD0, 32'hCAFE0002);

        // Asynchronous reset during a write data phase
        mem.delete();
        mem[32'hF00] = 32'h5A5A0001;
        mem[32'hF04] = 32'h5A5A0002;
        mem[32'hF08] = 32'h5A5A0003;
        cfg_waits = 0;
        mon_clear();
        do_start(32'hF00, 32'hF80, 16'd3);
        begin
            int t;
            t = 0;
            while (!(M_HTRANS == 2'b10 && M_HWRITE) && t < 50) begin @(posedge CLK); #1; t++; end
            chk("rst_found_wa", 32'(M_HTRANS == 2'b10 && M_HWRITE), 1);
        end
        @(posedge CLK); #1;
        chk("rst_wd_hwdata", M_HWDATA, 32'h5A5A0001);
        RES_N = 1'b0;
        #1;
        chk("arst_busy", 32'(BUSY), 0);
        chk("arst_done", 32'(DONE), 0);
        chk("arst_err", 32'(ERR), 0);
        chk("arst_htrans", 32'(M_HTRANS), 0);
        chk("arst_hwrite", 32'(M_HWRITE), 0);
        chk("arst_haddr", M_HADDR, 0);
        chk("arst_hwdata", M_HWDATA, 0);
        repeat (2) @(posedge CLK);
        #1;
        RES_N = 1'b1;
        mon_clear();
        repeat (8) @(posedge CLK);
        #1;
        chk("arst_no_done", 32'(done_cnt), 0);
        chk("arst_no_nonseq", 32'(n_nonseq), 0);
        chk("arst_no_write", 32'(mem.exists(32'hF80)), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
